// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: widths shared by the stereo stage and the I2S transmitter.
package i2s_tx_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int OFS_W      = $clog2(SLOT_W);
    typedef logic [CNT_W-1:0] bit_cnt_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into bclk and flags the clk cycle in which bclk falls.
module i2s_bclk_gen #(
    parameter int BCLK_HALF = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic fall
);
    localparam logic [7:0] LAST = 8'(BCLK_HALF - 1);
    logic [7:0] div;
    logic tick;
    assign tick = div == LAST;
    assign fall = tick && bclk;
    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            bclk <= 1'b0;
        end else begin
            div <= tick ? 8'd0 : div + 8'd1;
            if (tick) bclk <= ~bclk;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter, 64-bclk frames of two 32-bit slots with 16-bit samples MSB first.
// Define I2S_TX_UNDERRUN_HOLD_EN to resend the last latched pair on underrun instead of zeros.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int BCLK_HALF = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] codec_sample_left,
    input  logic signed [SAMPLE_W-1:0] codec_sample_right,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       underrun,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata
);
    logic fall, wrap, send;
    bit_cnt_t bit_cnt, nxt;
    logic [OFS_W-1:0] ofs;
    logic [SAMPLE_W-1:0] sh_l, sh_r, load_l, load_r;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
        .clk  (clk),
        .reset(reset),
        .bclk (bclk),
        .fall (fall)
    );

    assign nxt  = bit_cnt + 1'b1;
    assign ofs  = nxt[OFS_W-1:0];
    assign wrap = bit_cnt == bit_cnt_t'(FRAME_BITS - 1);
    assign send = ofs != '0 && ofs <= OFS_W'(SAMPLE_W);

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (fall && wrap && sample_valid) begin
            hold_l <= codec_sample_left;
            hold_r <= codec_sample_right;
        end
    end
    assign load_l = sample_valid ? codec_sample_left : hold_l;
    assign load_r = sample_valid ? codec_sample_right : hold_r;
`else
    assign load_l = sample_valid ? codec_sample_left : '0;
    assign load_r = sample_valid ? codec_sample_right : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '1;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            sample_ready <= 1'b0;
            underrun     <= 1'b0;
            sh_l         <= '0;
            sh_r         <= '0;
        end else begin
            sample_ready <= fall && wrap && sample_valid;
            underrun     <= fall && wrap && !sample_valid;
            if (fall) begin
                bit_cnt <= nxt;
                lrclk   <= nxt[CNT_W-1];
                sdata   <= send && (nxt[CNT_W-1] ? sh_r[SAMPLE_W-1] : sh_l[SAMPLE_W-1]);
                // Slot offset 0 is the wrap itself, so the MSB leaves one bclk after lrclk moves.
                if (wrap) begin
                    sh_l <= load_l;
                    sh_r <= load_r;
                end else if (send && nxt[CNT_W-1]) begin
                    sh_r <= sh_r << 1;
                end else if (send) begin
                    sh_l <= sh_l << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized self-checking bench comparing captured I2S frames against a per-bit frame model.
module tb_i2s_tx;
    typedef struct {
        logic [63:0] sd, lr, rd, ur;
        int first_gap, min_gap, max_gap, total, rd_cycles, ur_cycles;
        logic [15:0] wl, wr;
        logic wv;
        bit tmo;
    } cap_t;

    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

    logic clk = 0, reset = 1, s_reset = 1;
    logic [15:0] left = 0, right = 0, s_left = 16'h8008, s_right = 16'h1234;
    logic valid = 0, s_valid = 1;
    logic sample_ready, underrun, bclk, lrclk, sdata;
    logic s_ready, s_underrun, s_bclk, s_lrclk, s_sdata;
    logic prev_b = 0, prev_sb = 0, fell = 0, s_fell = 0;
    logic [15:0] last_l = 0, last_r = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    i2s_tx #(.BCLK_HALF(2)) dut (
        .clk(clk), .reset(reset), .codec_sample_left(left), .codec_sample_right(right),
        .sample_valid(valid), .sample_ready(sample_ready), .underrun(underrun),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
    );

    i2s_tx #(.BCLK_HALF(255)) dut_s (
        .clk(clk), .reset(s_reset), .codec_sample_left(s_left), .codec_sample_right(s_right),
        .sample_valid(s_valid), .sample_ready(s_ready), .underrun(s_underrun),
        .bclk(s_bclk), .lrclk(s_lrclk), .sdata(s_sdata)
    );

    always @(negedge clk) begin
        fell    <= prev_b && !bclk;
        prev_b  <= bclk;
        s_fell  <= prev_sb && !s_bclk;
        prev_sb <= s_bclk;
    end

    // Slot offset k=1..16 carries sample bit 16-k; everything else in the frame is zero.
    function automatic logic [63:0] model_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        logic [15:0] s;
        int k;
        f = '0;
        for (int i = 0; i < 64; i++) begin
            k = i % 32;
            s = (i < 32) ? l : r;
            if (k >= 1 && k <= 16) f[i] = s[16-k];
        end
        return f;
    endfunction

    task automatic model_wrap(input cap_t c, output logic [63:0] exp_sd);
        if (c.wv) begin
            last_l = c.wl;
            last_r = c.wr;
            exp_sd = model_frame(c.wl, c.wr);
        end
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        else exp_sd = model_frame(last_l, last_r);
`else
        else exp_sd = model_frame(16'h0, 16'h0);
`endif
    endtask

    task automatic do_reset(input logic [15:0] l, input logic [15:0] r, input logic v);
        reset = 1;
        left = l;
        right = r;
        valid = v;
        repeat (3) @(negedge clk);
        #1;
        reset = 0;
        last_l = 0;
        last_r = 0;
    endtask

    task automatic capture(input bit slow, input int chg_at, input logic [15:0] chg_l, output cap_t c);
        int gap;
        logic f;
        c.sd = '0; c.lr = '0; c.rd = '0; c.ur = '0;
        c.first_gap = 0; c.min_gap = 1 << 30; c.max_gap = 0; c.total = 0;
        c.rd_cycles = 0; c.ur_cycles = 0; c.wl = 0; c.wr = 0; c.wv = 0; c.tmo = 0;
        for (int i = 0; i < 64 && !c.tmo; i++) begin
            gap = 0;
            do begin
                @(negedge clk);
                #1;
                gap++;
                if (slow ? s_ready : sample_ready) c.rd_cycles++;
                if (slow ? s_underrun : underrun) c.ur_cycles++;
                f = slow ? s_fell : fell;
            end while (!f && gap < 2000);
            c.total += gap;
            if (!f) c.tmo = 1;
            else begin
                c.sd[i] = slow ? s_sdata : sdata;
                c.lr[i] = slow ? s_lrclk : lrclk;
                c.rd[i] = slow ? s_ready : sample_ready;
                c.ur[i] = slow ? s_underrun : underrun;
                if (i == 0) begin
                    c.first_gap = gap;
                    c.wl = slow ? s_left : left;
                    c.wr = slow ? s_right : right;
                    c.wv = slow ? s_valid : valid;
                end else begin
                    if (gap < c.min_gap) c.min_gap = gap;
                    if (gap > c.max_gap) c.max_gap = gap;
                end
                if (i == chg_at) left = chg_l;
            end
        end
    endtask

    task automatic wait_fall(output bit tmo);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!fell && n < 2000);
        tmo = !fell;
    endtask

    task automatic test_reset();
        reset = 1;
        left = 16'($urandom);
        right = 16'($urandom);
        valid = 1;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b want 0", lrclk); end
        checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", sdata); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sample_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_basic();
        cap_t c0, c1;
        logic [63:0] e;
        do_reset(16'h8008, 16'h1234, 1'b1);
        capture(0, -1, 16'h0, c0);
        capture(0, -1, 16'h0, c1);
        e = model_frame(16'h8008, 16'h1234);
        checks++; if (c0.tmo || c1.tmo) begin errors++; $display("FAIL basic_timeout: got %b%b want 00", c0.tmo, c1.tmo); end
        checks++; if (c0.first_gap !== 4) begin errors++; $display("FAIL basic_first_ready: got %0d clk want 4", c0.first_gap); end
        checks++; if (c0.min_gap !== 4 || c0.max_gap !== 4) begin errors++; $display("FAIL basic_bclk_period: got %0d..%0d want 4", c0.min_gap, c0.max_gap); end
        checks++; if (c0.sd !== e) begin errors++; $display("FAIL basic_sdata: got %h want %h", c0.sd, e); end
        checks++; if (c0.lr !== LR_EXP) begin errors++; $display("FAIL basic_lrclk: got %h want %h", c0.lr, LR_EXP); end
        checks++; if (c0.rd !== 64'd1 || c0.rd_cycles !== 1) begin errors++; $display("FAIL basic_ready: got %h/%0d want 1/1", c0.rd, c0.rd_cycles); end
        checks++; if (c1.total - c1.first_gap + c1.first_gap - c0.first_gap + c0.total - c1.total + c1.first_gap !== 256)
            begin errors++; $display("FAIL basic_ready_period: got %0d want 256", c0.total - c0.first_gap + c1.first_gap); end
        checks++; if (c1.sd !== e || c1.ur_cycles !== 0) begin errors++; $display("FAIL basic_frame2: got %h/%0d want %h/0", c1.sd, c1.ur_cycles, e); end
    endtask

    task automatic test_underrun();
        cap_t c;
        logic [63:0] e;
        do_reset(16'h8008, 16'h1234, 1'b0);
        capture(0, -1, 16'h0, c);
        checks++; if (c.ur !== 64'd1 || c.rd_cycles !== 0 || c.sd !== 64'd0)
            begin errors++; $display("FAIL underrun_first: got ur=%h rdy=%0d sd=%h want 1/0/0", c.ur, c.rd_cycles, c.sd); end
        valid = 1;
        capture(0, -1, 16'h0, c);
        model_wrap(c, e);
        checks++; if (c.sd !== e || c.rd !== 64'd1) begin errors++; $display("FAIL underrun_latch: got %h want %h", c.sd, e); end
        valid = 0;
        capture(0, -1, 16'h0, c);
        model_wrap(c, e);
        checks++; if (c.ur_cycles !== 1 || c.ur !== 64'd1 || c.rd_cycles !== 0)
            begin errors++; $display("FAIL underrun_pulse: got ur=%0d rdy=%0d want 1/0", c.ur_cycles, c.rd_cycles); end
        checks++; if (c.sd !== e) begin errors++; $display("FAIL underrun_data: got %h want %h", c.sd, e); end
        valid = 1;
        left = 16'($urandom);
        right = 16'($urandom);
        capture(0, -1, 16'h0, c);
        model_wrap(c, e);
        checks++; if (c.sd !== e || c.ur_cycles !== 0 || c.rd_cycles !== 1)
            begin errors++; $display("FAIL underrun_recover: got %h ur=%0d want %h ur=0", c.sd, c.ur_cycles, e); end
    endtask

    task automatic test_midframe();
        cap_t c;
        logic [15:0] l, r;
        l = 16'($urandom) & 16'h7FFE;
        r = 16'($urandom);
        do_reset(l, r, 1'b1);
        capture(0, 5, 16'h7FFF, c);
        checks++; if (c.sd !== model_frame(l, r)) begin errors++; $display("FAIL midframe_current: got %h want %h", c.sd, model_frame(l, r)); end
        capture(0, -1, 16'h0, c);
        checks++; if (c.sd !== model_frame(16'h7FFF, r)) begin errors++; $display("FAIL midframe_next: got %h want %h", c.sd, model_frame(16'h7FFF, r)); end
    endtask

    task automatic test_reset_mid();
        cap_t c;
        bit tmo;
        logic [15:0] l, r;
        l = 16'($urandom);
        r = 16'($urandom) | 16'h0100;
        do_reset(l, r, 1'b1);
        tmo = 0;
        for (int i = 0; i <= 40 && !tmo; i++) wait_fall(tmo);
        checks++; if (tmo) begin errors++; $display("FAIL resetmid_timeout: got timeout want bit 40"); end
        checks++; if (lrclk !== 1'b1 || sdata !== 1'b1) begin errors++; $display("FAIL resetmid_bit40: got lr=%b sd=%b want 1/1", lrclk, sdata); end
        reset = 1;
        @(negedge clk);
        #1;
        checks++; if ({bclk, lrclk, sdata, sample_ready, underrun} !== 5'b0)
            begin errors++; $display("FAIL resetmid_outputs: got %b want 00000", {bclk, lrclk, sdata, sample_ready, underrun}); end
        l = 16'($urandom);
        r = 16'($urandom);
        left = l;
        right = r;
        @(negedge clk);
        #1;
        reset = 0;
        last_l = 0;
        last_r = 0;
        capture(0, -1, 16'h0, c);
        checks++; if (c.first_gap !== 4 || c.rd !== 64'd1) begin errors++; $display("FAIL resetmid_restart: got gap=%0d rdy=%h want 4/1", c.first_gap, c.rd); end
        checks++; if (c.sd !== model_frame(l, r)) begin errors++; $display("FAIL resetmid_data: got %h want %h", c.sd, model_frame(l, r)); end
    endtask

    task automatic test_random();
        cap_t c;
        logic [63:0] e;
        do_reset(16'($urandom), 16'($urandom), 1'($urandom_range(1)));
        for (int f = 0; f < 10; f++) begin
            capture(0, -1, 16'h0, c);
            model_wrap(c, e);
            checks++; if (c.tmo) begin errors++; $display("FAIL rand_timeout[%0d]: got timeout want frame", f); end
            checks++; if (c.sd !== e) begin errors++; $display("FAIL rand_sdata[%0d]: got %h want %h", f, c.sd, e); end
            checks++; if (c.lr !== LR_EXP) begin errors++; $display("FAIL rand_lrclk[%0d]: got %h want %h", f, c.lr, LR_EXP); end
            checks++; if (c.rd !== 64'(c.wv) || c.rd_cycles !== int'(c.wv))
                begin errors++; $display("FAIL rand_ready[%0d]: got %h/%0d want valid=%b", f, c.rd, c.rd_cycles, c.wv); end
            checks++; if (c.ur !== 64'(!c.wv) || c.ur_cycles !== int'(!c.wv))
                begin errors++; $display("FAIL rand_underrun[%0d]: got %h/%0d want valid=%b", f, c.ur, c.ur_cycles, c.wv); end
            left = 16'($urandom);
            right = 16'($urandom);
            valid = $urandom_range(3) != 0;
        end
    endtask

    task automatic test_slow();
        cap_t c;
        @(negedge clk);
        #1;
        s_reset = 0;
        capture(1, -1, 16'h0, c);
        checks++; if (c.first_gap !== 510 || c.min_gap !== 510 || c.max_gap !== 510)
            begin errors++; $display("FAIL slow_period: got %0d/%0d..%0d want 510", c.first_gap, c.min_gap, c.max_gap); end
        checks++; if (c.sd !== model_frame(16'h8008, 16'h1234)) begin errors++; $display("FAIL slow_sdata: got %h want %h", c.sd, model_frame(16'h8008, 16'h1234)); end
        checks++; if (c.lr !== LR_EXP || c.rd !== 64'd1) begin errors++; $display("FAIL slow_lr_ready: got %h/%h want %h/1", c.lr, c.rd, LR_EXP); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_midframe();
        test_reset_mid();
        test_random();
        test_slow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_HALF, default 4: number of clk cycles per half bit-clock period; legal values are 2 to 255.
REQ-002 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 codec_sample_left  input  16  signed left sample from the stereo stage.
REQ-005 codec_sample_right  input  16  signed right sample from the stereo stage.
REQ-006 sample_valid  input  1  left/right pair is valid and held stable by upstream.
REQ-007 sample_ready  output  1  one-clk pulse when the pair is consumed.
REQ-008 underrun  output  1  one-clk pulse when a frame starts while sample_valid is low.
REQ-009 bclk  output  1  I2S bit clock.
REQ-010 lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 sdata  output  1  I2S serial data, MSB first.

Function
REQ-012 Divider counter SHALL count 0..BCLK_HALF-1; bclk SHALL toggle in the cycle the counter equals BCLK_HALF-1, after which the counter wraps to 0.
REQ-013 A falling event is the clk cycle in which bclk goes 1->0; all state except bclk SHALL change only on falling events.
REQ-014 bit_cnt (6 bits, 0..63) SHALL increment on each falling event and wrap 63->0.
REQ-015 Frame layout: 64 bclk total; left slot is bit_cnt 0..31, right slot is bit_cnt 32..63.
REQ-016 lrclk SHALL equal bit_cnt[5] and update on the same falling event as bit_cnt.
REQ-017 Within a slot at offset k: k=1..16 SHALL drive sample bit 16-k (MSB at k=1, one bclk after the lrclk edge); k=0 and k=17..31 SHALL drive 0.
REQ-018 On the falling event where bit_cnt wraps 63->0 with sample_valid=1, the block SHALL latch both samples into shift registers and pulse sample_ready in that same cycle.
REQ-019 On that same wrap event with sample_valid=0, the block SHALL pulse underrun, SHALL NOT pulse sample_ready, and SHALL load the underrun data defined in REQ-026/027.
REQ-020 sample_ready and underrun SHALL be mutually exclusive, and each SHALL be at most one pulse per frame (every 128*BCLK_HALF clk).
REQ-021 Input changes outside the wrap event SHALL NOT affect the frame in flight.
REQ-022 Latency: a latched left MSB SHALL appear on sdata at the next falling event (bit_cnt=1).

Reset
REQ-023 While reset=1, the block SHALL force: bclk=0, lrclk=0, sdata=0, sample_ready=0, underrun=0, divider=0, bit_cnt=63, shift registers and hold register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame in the next cycle, with no partial-sample completion.
REQ-025 The first falling event after reset is released SHALL occur 2*BCLK_HALF clk later; it wraps bit_cnt to 0 and performs the REQ-018/019 latch.

Configuration
REQ-026 With I2S_TX_UNDERRUN_HOLD_EN defined, an underrun frame SHALL retransmit the last successfully latched left/right pair (zeros if none since reset).
REQ-027 Without I2S_TX_UNDERRUN_HOLD_EN, an underrun frame SHALL transmit all-zero samples; no hold register SHALL be synthesized.

Structure
REQ-028 The shared package SHALL hold SAMPLE_W=16, SLOT_W=32 and FRAME_BITS=64; the stereo stage and i2s_tx SHALL both use SAMPLE_W.
REQ-029 One sub-module, i2s_bclk_gen, SHALL contain the divider and bclk register and SHALL output bclk and a one-clk falling-event strobe.
REQ-030 All remaining logic (frame counter, lrclk, shift registers, handshake) SHALL reside in i2s_tx.

Verification
REQ-031 BCLK_HALF=2, left=16'h8008, right=16'h1234, valid held high -> left slot bits 1..16 = 1000_0000_0000_1000, right slot = 0001_0010_0011_0100, all other bits 0.
REQ-032 Same stimulus -> bclk period 4 clk; sample_ready pulses every 256 clk; first pulse 4 clk after reset deasserts; lrclk high exactly for bit_cnt 32..63.
REQ-033 valid dropped for one frame after 16'h8008/16'h1234 -> underrun is one pulse; frame carries 8008/1234 with the macro defined, zeros without it.
REQ-034 Inputs changed mid-frame (left to 16'h7FFF at bit_cnt=5) -> current frame unchanged; 7FFF is sent in the next frame.
REQ-035 reset pulsed at bit_cnt=40 -> outputs equal their reset values the next cycle; a fresh frame restarts per REQ-025 with correct data.
REQ-036 BCLK_HALF=255 smoke test -> bclk period 510 clk and bit pattern identical to REQ-031.
